hall_call_dispatcher: RTL and testbench

//  Parametrised hall-call dispatcher for NUM_ELEV cars over NUM_FLOORS floors; successor to fixed 2-car/8-floor routing.

---
 rtl/hall_call_dispatcher_pkg.sv | 35 +++
 rtl/hall_req_fifo.sv | 59 +++++
 rtl/hall_call_dispatcher.sv | 208 ++++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hall_call_dispatcher_pkg.sv
// ============================================================================
// dispatch_pkg : shared types and cost helper for the hall-call dispatcher
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dispatch_pkg;

  // Widest floor index the request record can carry.
  localparam int FLOOR_W_MAX = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef struct packed {
    logic [FLOOR_W_MAX-1:0] floor;
    dir_e                   dir;
  } hall_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2
  } disp_state_e;

  function automatic logic [FLOOR_W_MAX:0] floor_cost(input logic [FLOOR_W_MAX-1:0] a,
                                                      input logic [FLOOR_W_MAX-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hall_req_fifo.sv
// ============================================================================
// hall_req_fifo : synchronous FIFO of hall requests with full/empty flags
// Revision      : 1.0
// ============================================================================
`default_nettype none

module hall_req_fifo
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  hall_req_t push_data,
  input  logic      pop,
  output hall_req_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  hall_req_t      mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hall_call_dispatcher.sv
// ============================================================================
// hall_call_dispatcher : merges, queues and issues hall calls to the best car
// Option macro         : DISPATCH_STATS_EN adds per-car assignment counters
// Revision             : 1.0
// ============================================================================
`default_nettype none

module hall_call_dispatcher
  import dispatch_pkg::*;
#(
  parameter  int NUM_FLOORS  = 8,
  parameter  int NUM_ELEV    = 2,
  parameter  int QUEUE_DEPTH = 16,
  localparam int FW          = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1,
  localparam int EW          = (NUM_ELEV > 1) ? $clog2(NUM_ELEV) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         request,
  input  logic [FW-1:0]                request_floor,
  input  logic                         request_dir,
  output logic                         request_ready,
  input  logic [NUM_ELEV-1:0][FW-1:0]  elev_floor,
  input  logic [NUM_ELEV-1:0]          elev_dir,
  input  logic [NUM_ELEV-1:0]          elev_idle,
  output logic                         assign_valid,
  output logic [EW-1:0]                assign_elev,
  output logic [FW-1:0]                assign_floor,
  output logic                         assign_dir,
  input  logic                         assign_ready,
`ifdef DISPATCH_STATS_EN
  output logic [NUM_ELEV-1:0][15:0]    assign_count,
`endif
  output logic                         illegal_req
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SELECT = SELECT;
  localparam logic [1:0] ST_ISSUE  = ISSUE;

  logic [1:0]            state_q, state_d;
  logic [EW-1:0]         assign_elev_q, assign_elev_d;
  logic [FW-1:0]         assign_floor_q, assign_floor_d;
  logic                  assign_dir_q, assign_dir_d;
  logic                  illegal_q, illegal_d;
  logic [NUM_FLOORS-1:0] pend_up_q, pend_up_d;
  logic [NUM_FLOORS-1:0] pend_dn_q, pend_dn_d;

  logic      fifo_full, fifo_empty;
  logic      accept, handshake, legal, dup, push;
  hall_req_t push_req, head;
  logic      head_ok;

  logic [NUM_ELEV-1:0]       elig;
  logic [NUM_ELEV-1:0][FW:0] cost;
  logic                      found;
  logic [EW-1:0]             best_idx;
  logic [FW:0]               best_cost;

  assign request_ready = !fifo_full;
  assign accept        = request && request_ready;
  assign assign_valid  = (state_q == ST_ISSUE);
  assign handshake     = assign_valid && assign_ready;
  assign assign_elev   = assign_elev_q;
  assign assign_floor  = assign_floor_q;
  assign assign_dir    = assign_dir_q;
  assign illegal_req   = illegal_q;

  always_comb begin
    push_req       = '0;
    push_req.floor = FLOOR_W_MAX'(request_floor);
    push_req.dir   = dir_e'(request_dir);
  end

  always_comb begin
    legal = ({1'b0, request_floor} < (FW+1)'(NUM_FLOORS));
    if (request_dir && (request_floor == FW'(NUM_FLOORS - 1))) legal = 1'b0;
    if (!request_dir && (request_floor == '0)) legal = 1'b0;
  end

  // A bit being cleared by this cycle's handshake no longer counts as pending.
  always_comb begin
    dup = 1'b0;
    if (legal) dup = request_dir ? pend_up_q[request_floor] : pend_dn_q[request_floor];
    if (handshake && (assign_floor_q == request_floor) && (assign_dir_q == request_dir)) dup = 1'b0;
  end

  assign push      = accept && legal && !dup;
  assign illegal_d = accept && !legal;

  always_comb begin
    pend_up_d = pend_up_q;
    pend_dn_d = pend_dn_q;
    if (handshake) begin
      if (assign_dir_q) pend_up_d[assign_floor_q] = 1'b0;
      else              pend_dn_d[assign_floor_q] = 1'b0;
    end
    if (push) begin
      if (request_dir) pend_up_d[request_floor] = 1'b1;
      else             pend_dn_d[request_floor] = 1'b1;
    end
  end

  hall_req_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_req),
    .pop       (handshake),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_ok = ({1'b0, head.floor} < (FLOOR_W_MAX+1)'(NUM_FLOORS));

  for (genvar e = 0; e < NUM_ELEV; e++) begin : g_car
    logic [FLOOR_W_MAX-1:0] car_floor;
    assign car_floor = FLOOR_W_MAX'(elev_floor[e]);
    assign elig[e]   = elev_idle[e]
                    || ((head.dir == DIR_UP)   &&  elev_dir[e] && (car_floor <= head.floor))
                    || ((head.dir == DIR_DOWN) && !elev_dir[e] && (car_floor >= head.floor));
    assign cost[e]   = (FW+1)'(floor_cost(car_floor, head.floor));
  end

  // Strict less-than keeps the lowest index on equal cost.
  always_comb begin
    found     = 1'b0;
    best_idx  = '0;
    best_cost = '1;
    for (int e = 0; e < NUM_ELEV; e++) begin
      if (elig[e] && (!found || (cost[e] < best_cost))) begin
        found     = 1'b1;
        best_idx  = EW'(e);
        best_cost = cost[e];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    assign_elev_d  = assign_elev_q;
    assign_floor_d = assign_floor_q;
    assign_dir_d   = assign_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (found && head_ok) begin
          state_d        = ST_ISSUE;
          assign_elev_d  = best_idx;
          assign_floor_d = head.floor[FW-1:0];
          assign_dir_d   = head.dir;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (assign_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      assign_elev_q  <= '0;
      assign_floor_q <= '0;
      assign_dir_q   <= 1'b0;
      illegal_q      <= 1'b0;
      pend_up_q      <= '0;
      pend_dn_q      <= '0;
    end else begin
      state_q        <= state_d;
      assign_elev_q  <= assign_elev_d;
      assign_floor_q <= assign_floor_d;
      assign_dir_q   <= assign_dir_d;
      illegal_q      <= illegal_d;
      pend_up_q      <= pend_up_d;
      pend_dn_q      <= pend_dn_d;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [NUM_ELEV-1:0][15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (handshake && (count_q[assign_elev_q] != 16'hFFFF)) begin
      count_d[assign_elev_q] = count_q[assign_elev_q] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign assign_count = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
// ============================================================================
// tb_hall_call_dispatcher : scoreboard bench for hall_call_dispatcher
// Revision                : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hall_call_dispatcher;

  typedef struct {
    int elev;
    int floor;
    int dir;
    int lat;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-floor instance
  logic            request, request_dir, request_ready;
  logic [2:0]      request_floor, assign_floor;
  logic [1:0][2:0] elev_floor;
  logic [1:0]      elev_dir, elev_idle;
  logic            assign_valid, assign_dir, assign_ready, illegal_req;
  logic [0:0]      assign_elev;

  // 16-floor instance, used to reach a full 16-entry queue with distinct calls
  logic            b_request, b_request_dir, b_request_ready;
  logic [3:0]      b_request_floor, b_assign_floor;
  logic [1:0][3:0] b_elev_floor;
  logic [1:0]      b_elev_dir, b_elev_idle;
  logic            b_assign_valid, b_assign_dir, b_assign_ready, b_illegal_req;
  logic [0:0]      b_assign_elev;

`ifdef DISPATCH_STATS_EN
  logic [1:0][15:0] assign_count, b_assign_count;
`endif

  hall_call_dispatcher #(.NUM_FLOORS(8), .NUM_ELEV(2), .QUEUE_DEPTH(16)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .request       (request),
    .request_floor (request_floor),
    .request_dir   (request_dir),
    .request_ready (request_ready),
    .elev_floor    (elev_floor),
    .elev_dir      (elev_dir),
    .elev_idle     (elev_idle),
    .assign_valid  (assign_valid),
    .assign_elev   (assign_elev),
    .assign_floor  (assign_floor),
    .assign_dir    (assign_dir),
    .assign_ready  (assign_ready),
`ifdef DISPATCH_STATS_EN
    .assign_count  (assign_count),
`endif
    .illegal_req   (illegal_req)
  );

  hall_call_dispatcher #(.NUM_FLOORS(16), .NUM_ELEV(2), .QUEUE_DEPTH(16)) u_dut_big (
    .clk           (clk),
    .reset         (reset),
    .request       (b_request),
    .request_floor (b_request_floor),
    .request_dir   (b_request_dir),
    .request_ready (b_request_ready),
    .elev_floor    (b_elev_floor),
    .elev_dir      (b_elev_dir),
    .elev_idle     (b_elev_idle),
    .assign_valid  (b_assign_valid),
    .assign_elev   (b_assign_elev),
    .assign_floor  (b_assign_floor),
    .assign_dir    (b_assign_dir),
    .assign_ready  (b_assign_ready),
`ifdef DISPATCH_STATS_EN
    .assign_count  (b_assign_count),
`endif
    .illegal_req   (b_illegal_req)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_t = 0;
  int   hs_cnt = 0, valid_cnt = 0, illegal_cnt = 0, b_hs_cnt = 0;
  exp_t sb_q[$];
  exp_t b_sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, req, $time);
    end
  endtask

  // Monitors sample just after the negedge, when inputs for the next edge are settled.
  always begin : mon_main
    exp_t e;
    @(negedge clk);
    #1;
    if (!reset) begin
      if (assign_valid) valid_cnt++;
      if (illegal_req) illegal_cnt++;
      if (assign_valid && assign_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_assign", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("assign_elev", int'(assign_elev), e.elev);
          check_eq("assign_floor", int'(assign_floor), e.floor);
          check_eq("assign_dir", int'(assign_dir), e.dir);
          if (e.lat > 0) check_eq("latency", cyc - e.t, e.lat);
        end
      end
    end
  end

  always begin : mon_big
    exp_t e;
    @(negedge clk);
    #1;
    if (!reset && b_assign_valid && b_assign_ready) begin
      b_hs_cnt++;
      if (b_sb_q.size() == 0) begin
        check_eq("big_unexpected_assign", 1, 0);
      end else begin
        e = b_sb_q.pop_front();
        check_eq("big_assign_elev", int'(b_assign_elev), e.elev);
        check_eq("big_assign_floor", int'(b_assign_floor), e.floor);
        check_eq("big_assign_dir", int'(b_assign_dir), e.dir);
      end
    end
  end

  task automatic send(input int f, input bit d);
    @(negedge clk);
    request = 1'b1; request_floor = 3'(f); request_dir = d; last_t = cyc;
    @(negedge clk);
    request = 1'b0;
  endtask

  task automatic expect_assign(input int elev, input int f, input int d, input int lat);
    sb_q.push_back('{elev, f, d, lat, last_t});
  endtask

  task automatic b_send(input int f, input bit d);
    @(negedge clk);
    b_request = 1'b1; b_request_floor = 4'(f); b_request_dir = d;
    @(negedge clk);
    b_request = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    #2;
    check_eq("drain_remaining", sb_q.size(), 0);
  endtask

  task automatic b_wait_drain(input int budget);
    int n = 0;
    while (b_sb_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    #2;
    check_eq("big_drain_remaining", b_sb_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h0, i0, v0, n;
    request = 0; request_floor = '0; request_dir = 0;
    elev_floor = '0; elev_dir = '0; elev_idle = '0; assign_ready = 1;
    b_request = 0; b_request_floor = '0; b_request_dir = 0;
    b_elev_floor = '0; b_elev_dir = '0; b_elev_idle = '0; b_assign_ready = 1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_request_ready", request_ready, 1);
    check_eq("rst_assign_valid", assign_valid, 0);
    check_eq("rst_illegal_req", illegal_req, 0);
    check_eq("rst_assign_elev", int'(assign_elev), 0);
    check_eq("rst_assign_floor", int'(assign_floor), 0);
    check_eq("rst_assign_dir", assign_dir, 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle cars at 0 and 6, call at 5 up: nearer car 1, three cycles after the request cycle
    elev_idle = 2'b11; elev_floor[0] = 3'd0; elev_floor[1] = 3'd6; elev_dir = 2'b00;
    send(5, 1); expect_assign(1, 5, 1, 3);
    wait_drain(20);

    // Moving cars: car0 at 2 going up, car1 at 4 going down
    elev_idle = 2'b00; elev_floor[0] = 3'd2; elev_floor[1] = 3'd4; elev_dir = 2'b01;
    send(3, 1); expect_assign(0, 3, 1, 0);
    wait_drain(20);
    send(3, 0); expect_assign(1, 3, 0, 0);
    wait_drain(20);

    // Equal cost tie goes to car 0
    elev_idle = 2'b11; elev_floor[0] = 3'd1; elev_floor[1] = 3'd5; elev_dir = 2'b00;
    send(3, 0); expect_assign(0, 3, 0, 3);
    wait_drain(20);

    // Three identical calls while the first is held: merged into one assignment
    repeat (3) @(negedge clk);
    assign_ready = 1'b0;
    h0 = hs_cnt;
    send(3, 0); expect_assign(0, 3, 0, 0);
    send(3, 0);
    send(3, 0);
    repeat (4) @(negedge clk);
    assign_ready = 1'b1;
    wait_drain(20);
    repeat (10) @(negedge clk);
    #2;
    check_eq("dup_merge_count", hs_cnt - h0, 1);

    // Pending bit is cleared after the handshake, so the same call is accepted anew
    send(3, 0); expect_assign(0, 3, 0, 3);
    wait_drain(20);

    // Illegal calls: top floor up, floor 0 down
    repeat (3) @(negedge clk);
    i0 = illegal_cnt; v0 = valid_cnt;
    send(7, 1);
    send(0, 0);
    repeat (6) @(negedge clk);
    #2;
    check_eq("illegal_pulses", illegal_cnt - i0, 2);
    check_eq("illegal_no_valid", valid_cnt - v0, 0);

    // Fill the 16-entry queue with distinct calls on the 16-floor instance
    b_elev_idle = 2'b11; b_elev_floor = '0; b_elev_dir = 2'b00;
    b_assign_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 15) begin
        b_send(i, 1); b_sb_q.push_back('{0, i, 1, 0, 0});
      end else begin
        b_send(1, 0); b_sb_q.push_back('{0, 1, 0, 0, 0});
      end
    end
    #1;
    check_eq("full_ready_low", b_request_ready, 0);
    @(negedge clk);
    b_request = 1'b1; b_request_floor = 4'd2; b_request_dir = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("full_ready_held_low", b_request_ready, 0);
    b_request = 1'b0;
    @(negedge clk);
    b_assign_ready = 1'b1;
    b_wait_drain(55);
    check_eq("full_drain_ready_high", b_request_ready, 1);
    repeat (6) @(negedge clk);

    // Reset in the middle of an offer
    assign_ready = 1'b0;
    elev_idle = 2'b11; elev_floor[0] = 3'd0; elev_floor[1] = 3'd6; elev_dir = 2'b00;
    send(4, 1);
    n = 0;
    while (!assign_valid && n < 20) begin @(negedge clk); n++; end
    check_eq("mid_offer_valid_seen", assign_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_valid_drop", assign_valid, 0);
    check_eq("async_reset_ready", request_ready, 1);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    assign_ready = 1'b1;
    repeat (2) @(negedge clk);
    send(4, 1); expect_assign(1, 4, 1, 3);
    wait_drain(20);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
